// File: rtl/wisc_pkg.sv
// Shared WISC core constants: instruction encodings, register-id width and
// the ID/EX update selector used by the pipeline stage.
package wisc_pkg;

  localparam int unsigned REG_ID_W = 3;

  localparam logic [4:0] OP_LD  = 5'b10001;
  localparam logic [4:0] OP_ST  = 5'b10000;
  localparam logic [4:0] OP_NOP = 5'b00001;

  // NOP is the opcode with every operand field zero: 16'h0800
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'b000_0000_0000};

  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_BUBBLE = 2'd1,
    UPD_HIT    = 2'd2,
    UPD_LOAD   = 2'd3
  } idex_upd_t;

  function automatic logic [REG_ID_W-1:0] rs_field(input logic [15:0] instr);
    return instr[10:8];
  endfunction

  function automatic logic [REG_ID_W-1:0] rt_field(input logic [15:0] instr);
    return instr[7:5];
  endfunction

endpackage

// File: rtl/idex_stage_load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX will write. R0 is an ordinary register here.
module load_use_detect
  import wisc_pkg::*;
(
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_reg_write,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                id_valid,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  output logic                hit
);

  logic rs_match_s;
  logic rt_match_s;
  logic ex_load_s;

  assign rs_match_s = id_uses_rs & (ex_rd == id_rs);
  assign rt_match_s = id_uses_rt & (ex_rd == id_rt);
  assign ex_load_s  = ex_valid & ex_mem_read & ex_reg_write;
  assign hit        = ex_load_s & id_valid & (rs_match_s | rt_match_s);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register of the WISC core with load-use stall, EX flush,
// memory-stall freeze and a saturating count of inserted bubbles.
module idex_stage
  import wisc_pkg::*;
#(
  parameter int DW     = 16,
  parameter int CTRL_W = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       ifid_Instr,
  input  logic [DW-1:0]       ifid_PC,
  input  logic                ifid_valid,
  input  logic [DW-1:0]       ifid_A,
  input  logic [DW-1:0]       ifid_B,
  input  logic [DW-1:0]       ifid_Imm,
  input  logic                ifid_usesRs,
  input  logic                ifid_usesRt,
  input  logic                ifid_RegWriteEn,
  input  logic [2:0]          ifid_RegD,
  input  logic                ifid_MemRead,
  input  logic [CTRL_W-1:0]   ifid_ctrl,
  input  logic                flush,
  input  logic                mem_stall,
  output logic                hazard_stall,
  output logic [DW-1:0]       idex_Instr,
  output logic [DW-1:0]       idex_PC,
  output logic [DW-1:0]       idex_A,
  output logic [DW-1:0]       idex_B,
  output logic [DW-1:0]       idex_Imm,
  output logic                idex_valid,
  output logic                idex_RegWriteEn,
  output logic [2:0]          idex_RegD,
  output logic                idex_MemRead,
  output logic [CTRL_W-1:0]   idex_ctrl,
  output logic [15:0]         bubble_count
);

  logic      hit_s;
  idex_upd_t upd_sel_s;
  logic [15:0] bubble_cnt_r;
  logic [15:0] bubble_next_s;

  load_use_detect u_detect (
    .ex_valid     (idex_valid),
    .ex_mem_read  (idex_MemRead),
    .ex_reg_write (idex_RegWriteEn),
    .ex_rd        (idex_RegD),
    .id_valid     (ifid_valid),
    .id_uses_rs   (ifid_usesRs),
    .id_uses_rt   (ifid_usesRt),
    .id_rs        (rs_field(ifid_Instr[15:0])),
    .id_rt        (rt_field(ifid_Instr[15:0])),
    .hit          (hit_s)
  );

  // A flush squashes the IF/ID instruction too, so it must not hold the front end
  assign hazard_stall = hit_s & ~flush;
  assign bubble_count = bubble_cnt_r;

  // Priority select for the next ID/EX contents and the saturating count
  always_comb begin
    upd_sel_s     = UPD_LOAD;
    bubble_next_s = bubble_cnt_r;
    if (mem_stall) begin
      upd_sel_s = UPD_HOLD;
    end else if (flush) begin
      upd_sel_s = UPD_BUBBLE;
    end else if (hit_s) begin
      upd_sel_s = UPD_HIT;
    end else begin
      upd_sel_s = UPD_LOAD;
    end
    if (bubble_cnt_r == 16'hFFFF) begin
      bubble_next_s = bubble_cnt_r;
    end else begin
      bubble_next_s = bubble_cnt_r + 16'd1;
    end
  end

  // Pipeline register block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_Instr      <= NOP_INSTR[DW-1:0];
      idex_PC         <= {DW{1'b0}};
      idex_A          <= {DW{1'b0}};
      idex_B          <= {DW{1'b0}};
      idex_Imm        <= {DW{1'b0}};
      idex_valid      <= 1'b0;
      idex_RegWriteEn <= 1'b0;
      idex_RegD       <= 3'd0;
      idex_MemRead    <= 1'b0;
      idex_ctrl       <= {CTRL_W{1'b0}};
    end else begin
      case (upd_sel_s)
        UPD_HOLD: begin
        end
        UPD_LOAD: begin
          idex_Instr      <= ifid_Instr;
          idex_PC         <= ifid_PC;
          idex_A          <= ifid_A;
          idex_B          <= ifid_B;
          idex_Imm        <= ifid_Imm;
          idex_valid      <= ifid_valid;
          idex_RegWriteEn <= ifid_RegWriteEn;
          idex_RegD       <= ifid_RegD;
          idex_MemRead    <= ifid_MemRead;
          idex_ctrl       <= ifid_ctrl;
        end
        default: begin
          idex_Instr      <= NOP_INSTR[DW-1:0];
          idex_PC         <= {DW{1'b0}};
          idex_A          <= {DW{1'b0}};
          idex_B          <= {DW{1'b0}};
          idex_Imm        <= {DW{1'b0}};
          idex_valid      <= 1'b0;
          idex_RegWriteEn <= 1'b0;
          idex_RegD       <= 3'd0;
          idex_MemRead    <= 1'b0;
          idex_ctrl       <= {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // Bubble counter advances only for load-use bubbles, never for flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= 16'd0;
    end else if (upd_sel_s == UPD_HIT) begin
      bubble_cnt_r <= bubble_next_s;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage; inputs change and outputs are
// sampled on the falling clock edge.
module tb_idex_stage;
  import wisc_pkg::*;

  localparam logic [4:0] OP_ADD = 5'b11011;
  localparam logic [4:0] OP_SUB = 5'b11001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ifid_Instr, ifid_PC, ifid_A, ifid_B, ifid_Imm;
  logic        ifid_valid, ifid_usesRs, ifid_usesRt, ifid_RegWriteEn, ifid_MemRead;
  logic [2:0]  ifid_RegD;
  logic [11:0] ifid_ctrl;
  logic        flush, mem_stall;
  logic        hazard_stall;
  logic [15:0] idex_Instr, idex_PC, idex_A, idex_B, idex_Imm;
  logic        idex_valid, idex_RegWriteEn, idex_MemRead;
  logic [2:0]  idex_RegD;
  logic [11:0] idex_ctrl;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ld3, ld4, add3, sub12, nodep, ld3b, ldr3;

  always #5 clk = ~clk;

  idex_stage #(.DW(16), .CTRL_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_Instr(ifid_Instr), .ifid_PC(ifid_PC), .ifid_valid(ifid_valid),
    .ifid_A(ifid_A), .ifid_B(ifid_B), .ifid_Imm(ifid_Imm),
    .ifid_usesRs(ifid_usesRs), .ifid_usesRt(ifid_usesRt),
    .ifid_RegWriteEn(ifid_RegWriteEn), .ifid_RegD(ifid_RegD),
    .ifid_MemRead(ifid_MemRead), .ifid_ctrl(ifid_ctrl),
    .flush(flush), .mem_stall(mem_stall), .hazard_stall(hazard_stall),
    .idex_Instr(idex_Instr), .idex_PC(idex_PC), .idex_A(idex_A), .idex_B(idex_B),
    .idex_Imm(idex_Imm), .idex_valid(idex_valid), .idex_RegWriteEn(idex_RegWriteEn),
    .idex_RegD(idex_RegD), .idex_MemRead(idex_MemRead), .idex_ctrl(idex_ctrl),
    .bubble_count(bubble_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 2'b00};
  endfunction

  task automatic drive(input logic [15:0] instr, input logic [2:0] rd, input logic mr,
                       input logic rwe, input logic urs, input logic urt);
    ifid_Instr      = instr;
    ifid_PC         = instr + 16'h0002;
    ifid_A          = instr ^ 16'hA5A5;
    ifid_B          = instr ^ 16'h5A5A;
    ifid_Imm        = {11'd0, instr[4:0]};
    ifid_valid      = 1'b1;
    ifid_RegD       = rd;
    ifid_MemRead    = mr;
    ifid_RegWriteEn = rwe;
    ifid_usesRs     = urs;
    ifid_usesRt     = urt;
    ifid_ctrl       = instr[11:0] ^ 12'hC3C;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_bubble(input string tag);
    check_val({tag, "_valid"}, {31'd0, idex_valid}, 32'd0);
    check_val({tag, "_instr"}, {16'd0, idex_Instr}, 32'h0800);
    check_val({tag, "_ctrl"}, {20'd0, idex_ctrl}, 32'd0);
    check_val({tag, "_memrd"}, {31'd0, idex_MemRead}, 32'd0);
  endtask

  task automatic check_captured(input string tag, input logic [15:0] instr, input logic [2:0] rd);
    check_val({tag, "_instr"}, {16'd0, idex_Instr}, {16'd0, instr});
    check_val({tag, "_pc"}, {16'd0, idex_PC}, {16'd0, instr + 16'h0002});
    check_val({tag, "_a"}, {16'd0, idex_A}, {16'd0, instr ^ 16'hA5A5});
    check_val({tag, "_b"}, {16'd0, idex_B}, {16'd0, instr ^ 16'h5A5A});
    check_val({tag, "_valid"}, {31'd0, idex_valid}, 32'd1);
    check_val({tag, "_rd"}, {29'd0, idex_RegD}, {29'd0, rd});
  endtask

  // one load followed by a dependent ADD: exactly one bubble
  task automatic load_use_pair(input string tag, input logic [15:0] exp_cnt);
    drive(ld3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(add3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check_val({tag, "_stall"}, {31'd0, hazard_stall}, 32'd1);
    step();
    check_val({tag, "_cnt"}, {16'd0, bubble_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    ld3   = mk(OP_LD, 3'd2, 3'd3, 3'd0);
    ld4   = mk(OP_LD, 3'd2, 3'd4, 3'd0);
    ld3b  = mk(OP_LD, 3'd3, 3'd3, 3'd0);
    ldr3  = mk(OP_ST, 3'd3, 3'd6, 3'd0);
    add3  = mk(OP_ADD, 3'd3, 3'd2, 3'd1);
    sub12 = mk(OP_SUB, 3'd1, 3'd2, 3'd5);
    nodep = mk(OP_ADD, 3'd5, 3'd3, 3'd3);
    rst_n = 1'b0;
    flush = 1'b0;
    mem_stall = 1'b0;
    drive(16'h1234, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset holds with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      flush = 1'($urandom);
      mem_stall = 1'($urandom);
      step();
      check_val("rst_instr", {16'd0, idex_Instr}, 32'h0800);
      check_val("rst_valid", {31'd0, idex_valid}, 32'd0);
      check_val("rst_cnt", {16'd0, bubble_count}, 32'd0);
      check_val("rst_stall", {31'd0, hazard_stall}, 32'd0);
      check_val("rst_ctrl", {20'd0, idex_ctrl}, 32'd0);
    end
    flush = 1'b0;
    mem_stall = 1'b0;

    // load-use stall on Rs
    rst_n = 1'b1;
    drive(ld3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_captured("ld3", ld3, 3'd3);
    check_val("ld3_memrd", {31'd0, idex_MemRead}, 32'd1);
    drive(add3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check_val("lu_stall", {31'd0, hazard_stall}, 32'd1);
    step();
    check_bubble("lu_bub");
    check_val("lu_cnt", {16'd0, bubble_count}, 32'd1);
    check_val("lu_stall_after", {31'd0, hazard_stall}, 32'd0);
    step();
    check_captured("lu_add", add3, 3'd1);

    // Rt matches but instruction does not read Rt
    drive(ld3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(nodep, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check_val("nort_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    check_captured("nort", nodep, 3'd3);

    // ALU producer of R3 does not stall a consumer of R3
    drive(add3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    check_val("alu_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    check_captured("alu", add3, 3'd1);
    check_val("alu_cnt", {16'd0, bubble_count}, 32'd1);

    // flush wins over hit
    drive(ld3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(add3, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    check_val("fl_stall", {31'd0, hazard_stall}, 32'd0);
    step();
    flush = 1'b0;
    check_bubble("fl_bub");
    check_val("fl_cnt", {16'd0, bubble_count}, 32'd1);

    // freeze: nothing moves while mem_stall is high
    drive(ld4, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_captured("fz_pre", ld4, 3'd4);
    mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(mk(OP_ADD, 3'd4, 3'(i), 3'd2) + 16'(i), 3'd2, 1'b0, 1'b1, 1'b1, 1'b1);
      flush = (i == 1) || (i == 2);
      step();
      check_captured("fz_hold", ld4, 3'd4);
      check_val("fz_cnt", {16'd0, bubble_count}, 32'd1);
    end
    mem_stall = 1'b0;
    flush = 1'b0;
    drive(sub12, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check_captured("fz_sub", sub12, 3'd5);

    // back-to-back loads to R3, each consumer stalls exactly once
    drive(ld3, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(ld3b, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check_val("bb_stall1", {31'd0, hazard_stall}, 32'd1);
    step();
    check_val("bb_cnt1", {16'd0, bubble_count}, 32'd2);
    check_val("bb_nostall1", {31'd0, hazard_stall}, 32'd0);
    step();
    check_captured("bb_ld2", ld3b, 3'd3);
    drive(ldr3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check_val("bb_stall2", {31'd0, hazard_stall}, 32'd1);
    step();
    check_val("bb_nostall2", {31'd0, hazard_stall}, 32'd0);
    step();
    check_captured("bb_st", ldr3, 3'd0);
    check_val("bb_cnt2", {16'd0, bubble_count}, 32'd3);

    // saturation: preload the counter near the top, then three more events
    force dut.bubble_cnt_r = 16'hFFFD;
    #1;
    release dut.bubble_cnt_r;
    load_use_pair("sat1", 16'hFFFE);
    load_use_pair("sat2", 16'hFFFF);
    load_use_pair("sat3", 16'hFFFF);

    // reset mid-sequence, then first edge after release captures
    drive(ld4, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check_val("mrst_instr", {16'd0, idex_Instr}, 32'h0800);
    check_val("mrst_valid", {31'd0, idex_valid}, 32'd0);
    check_val("mrst_cnt", {16'd0, bubble_count}, 32'd0);
    step();
    rst_n = 1'b1;
    drive(sub12, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check_captured("mrst_sub", sub12, 3'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline stage of the 5-stage WISC core: registers decode outputs and presents them to EX.
- EX consumes them: the operand muxes and the forwarding logic use idex_Instr[10:8] (Rs) and idex_Instr[7:5] (Rt).
- Also performs load-use hazard detection. On a hit it stalls PC and IF/ID and injects one bubble into EX.
- Handles branch/jump flush from EX and a global memory-stall freeze.

Parameters:
- DW, 16, datapath width (instruction, PC, operand data)
- CTRL_W, 12, width of the opaque downstream control bundle passed through untouched

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ifid_Instr  in  DW  decoded instruction word
- ifid_PC  in  DW  PC+2 of the instruction
- ifid_valid  in  1  IF/ID holds a real instruction
- ifid_A  in  DW  register-file read data, port 1 (Rs)
- ifid_B  in  DW  register-file read data, port 2 (Rt)
- ifid_Imm  in  DW  sign/zero-extended immediate
- ifid_usesRs  in  1  decoder: instruction reads Rs
- ifid_usesRt  in  1  decoder: instruction reads Rt (match_both class)
- ifid_RegWriteEn  in  1  writes register file
- ifid_RegD  in  3  destination register
- ifid_MemRead  in  1  instruction is a load
- ifid_ctrl  in  CTRL_W  remaining EX/MEM/WB controls
- flush  in  1  branch/jump taken in EX; squash ID/EX
- mem_stall  in  1  memory busy; freeze whole pipe
- hazard_stall  out  1  hold PC and IF/ID this cycle
- idex_Instr  out  DW  registered instruction
- idex_PC, idex_A, idex_B, idex_Imm  out  DW each  registered copies
- idex_valid  out  1  EX holds a real instruction
- idex_RegWriteEn  out  1  registered
- idex_RegD  out  3  registered
- idex_MemRead  out  1  registered
- idex_ctrl  out  CTRL_W  registered
- bubble_count  out  16  number of load-use bubbles inserted, saturating

Behaviour:
- Reset (rst_n low, async):
  - idex_Instr = NOP (16'h0800).
  - All other idex_* outputs = 0, including idex_valid = 0.
  - bubble_count = 0.
  - hazard_stall is combinational and evaluates to 0 while reset holds the stage empty.
- Load-use detect (combinational):
  - hit = idex_valid & idex_MemRead & idex_RegWriteEn & ifid_valid & ((ifid_usesRs & idex_RegD == ifid_Instr[10:8]) | (ifid_usesRt & idex_RegD == ifid_Instr[7:5])).
  - hazard_stall = hit & ~flush.
  - R0 is a normal register in WISC; no R0 exclusion.
- Per-edge update, priority highest first:
  1. mem_stall: all registers hold, bubble_count unchanged. A flush asserted during a freeze is ignored; EX holds flush high until the freeze releases.
  2. flush: load bubble (NOP, all controls 0, valid 0). Flush wins over hit, because the IF/ID instruction is also being squashed.
  3. hit: load bubble; bubble_count increments unless already 16'hFFFF. IF/ID holds via hazard_stall, so next cycle the same instruction re-evaluates against the bubble (no hit) and is captured.
  4. else: capture all ifid_* fields; idex_valid = ifid_valid.
- Latency: one cycle from ifid_* to idex_*. A load-use pair costs exactly one bubble; the MEM/WB forward path covers the rest.
- Back-to-back loads to the same register: each dependent consumer stalls once, never twice.
- Reset deasserting mid-sequence: the first edge after release behaves as "else" with the current inputs.

Decomposition:
- Shared package wisc_pkg:
  - NOP_INSTR = 16'h0800
  - opcode constants (OP_LD = 5'b10001, OP_ST = 5'b10000, OP_NOP = 5'b00001)
  - REG_ID_W = 3
- One sub-module: load_use_detect, the pure-combinational hit logic. The stage itself holds the register block and the priority mux.

Test Plan:
- Reset: hold rst_n low for 3 cycles with random inputs -> idex_Instr = 16'h0800, idex_valid = 0, bubble_count = 0; no change on clk edges.
- Load-use stall: EX holds LD R3 (MemRead = 1, RegWriteEn = 1, RegD = 3, valid = 1); ID holds ADD using Rs = 3 -> hazard_stall = 1; next edge idex_valid = 0, idex_Instr = NOP, bubble_count = 1; following edge the ADD is captured and hazard_stall = 0.
- No-stall cases:
  - ADD reads Rt = 3 but ifid_usesRt = 0 -> hazard_stall = 0.
  - Producer is an ALU op with RegD = 3 (MemRead = 0) -> hazard_stall = 0, ADD captured immediately.
- Flush vs hit: hit conditions true and flush = 1 -> hazard_stall = 0; next edge inserts a bubble; bubble_count unchanged.
- Freeze: mem_stall = 1 for 4 cycles with flush pulsed and inputs changing -> all idex_* outputs and bubble_count constant. After release with ifid = SUB (valid) and no flush, the SUB is captured on the next edge.
- Saturation: preload 0xFFFE load-use events, then issue 3 more -> bubble_count reaches 16'hFFFF and stays there.
